// File: rtl/pixel_instr_fifo.sv
// rtl/pixel_instr_fifo.sv - FWFT circular-buffer FIFO for pixel instructions with level, prefetch request and underrun flag
module pixel_instr_fifo #(
    parameter int WIDTH     = 18,
    parameter int DEPTH     = 4,
    parameter int LOW_WATER = 1,
    parameter bit HOLD_LAST = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       fetch_req,
    output logic                       underrun
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [LW-1:0]    level_q;
    logic             underrun_q;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));
    assign push  = wr_valid && !full && !flush;
    assign pop   = rd_ready && !empty && !flush;

    assign wr_ready  = !full;
    assign rd_valid  = !empty;
    assign level     = level_q;
    assign fetch_req = (level_q <= LW'(LOW_WATER));
    assign underrun  = underrun_q;

    // Storage carries no reset; stale entries are never visible because rd_valid gates them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            level_q    <= '0;
            underrun_q <= 1'b0;
        end else if (flush) begin
            wptr       <= '0;
            rptr       <= '0;
            level_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            if (rd_ready && empty) begin
                underrun_q <= 1'b1;
            end
        end
    end

    // The held word survives flush so the display keeps its last colour across a frame restart.
    generate
        if (HOLD_LAST) begin : g_hold
            logic [WIDTH-1:0] last_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    last_q <= '0;
                end else if (pop) begin
                    last_q <= mem[rptr];
                end
            end
            assign rd_data = empty ? last_q : mem[rptr];
        end else begin : g_zero
            assign rd_data = empty ? '0 : mem[rptr];
        end
    endgenerate

endmodule

// File: tb/tb_pixel_instr_fifo.sv
// tb/tb_pixel_instr_fifo.sv - directed table-driven bench for pixel_instr_fifo (default and 8x12 no-hold builds)
module tb_pixel_instr_fifo;

    logic        clk;
    logic        rst_n;
    logic [17:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [17:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        flush;
    logic [2:0]  level;
    logic        fetch_req;
    logic        underrun;

    logic        rst8_n;
    logic [11:0] wr_data8;
    logic        wr_valid8;
    logic        wr_ready8;
    logic [11:0] rd_data8;
    logic        rd_valid8;
    logic        rd_ready8;
    logic        flush8;
    logic [3:0]  level8;
    logic        fetch_req8;
    logic        underrun8;

    int errors = 0;
    int checks = 0;

    pixel_instr_fifo u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .flush     (flush),
        .level     (level),
        .fetch_req (fetch_req),
        .underrun  (underrun)
    );

    pixel_instr_fifo #(
        .WIDTH     (12),
        .DEPTH     (8),
        .LOW_WATER (3),
        .HOLD_LAST (1'b0)
    ) u_dut8 (
        .clk       (clk),
        .rst_n     (rst8_n),
        .wr_data   (wr_data8),
        .wr_valid  (wr_valid8),
        .wr_ready  (wr_ready8),
        .rd_data   (rd_data8),
        .rd_valid  (rd_valid8),
        .rd_ready  (rd_ready8),
        .flush     (flush8),
        .level     (level8),
        .fetch_req (fetch_req8),
        .underrun  (underrun8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic        wr_valid;
        logic [17:0] wr_data;
        logic        rd_ready;
        logic [2:0]  lvl;
        logic        wrdy;
        logic        rv;
        logic [17:0] rd;
        logic        fr;
        logic        ur;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rn, logic fl, logic wv, logic [17:0] wd, logic rr,
                                logic [2:0] lv, logic wrd, logic rvl, logic [17:0] rdd,
                                logic frq, logic urn);
        vec_t v;
        v.rst_n = rn; v.flush = fl; v.wr_valid = wv; v.wr_data = wd; v.rd_ready = rr;
        v.lvl = lv; v.wrdy = wrd; v.rv = rvl; v.rd = rdd; v.fr = frq; v.ur = urn;
        return v;
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", nm, idx, act, exp);
        end
    endtask

    initial begin
        // rst_n flush wv  wr_data   rr | lvl wrdy rv rd_data  fetch und
        vecs.push_back(mk(0, 0, 0, 18'h00000, 0,  3'd0, 1, 0, 18'h00000, 1, 0)); // 0 reset
        vecs.push_back(mk(1, 0, 1, 18'h00001, 0,  3'd1, 1, 1, 18'h00001, 1, 0)); // 1 fill
        vecs.push_back(mk(1, 0, 1, 18'h00002, 0,  3'd2, 1, 1, 18'h00001, 0, 0));
        vecs.push_back(mk(1, 0, 1, 18'h00003, 0,  3'd3, 1, 1, 18'h00001, 0, 0));
        vecs.push_back(mk(1, 0, 1, 18'h00004, 0,  3'd4, 0, 1, 18'h00001, 0, 0));
        vecs.push_back(mk(1, 0, 1, 18'h3FFFF, 0,  3'd4, 0, 1, 18'h00001, 0, 0)); // 5 rejected
        vecs.push_back(mk(1, 0, 0, 18'h00000, 1,  3'd3, 1, 1, 18'h00002, 0, 0)); // 6 drain
        vecs.push_back(mk(1, 0, 0, 18'h00000, 1,  3'd2, 1, 1, 18'h00003, 0, 0));
        vecs.push_back(mk(1, 0, 0, 18'h00000, 1,  3'd1, 1, 1, 18'h00004, 1, 0));
        vecs.push_back(mk(1, 0, 0, 18'h00000, 1,  3'd0, 1, 0, 18'h00004, 1, 0)); // 9 hold last
        vecs.push_back(mk(1, 0, 0, 18'h00000, 1,  3'd0, 1, 0, 18'h00004, 1, 1)); // 10 underrun
        vecs.push_back(mk(1, 0, 0, 18'h00000, 0,  3'd0, 1, 0, 18'h00004, 1, 1)); // 11 sticky
        vecs.push_back(mk(1, 0, 1, 18'h00010, 0,  3'd1, 1, 1, 18'h00010, 1, 1)); // 12 refill
        vecs.push_back(mk(1, 0, 1, 18'h00011, 0,  3'd2, 1, 1, 18'h00010, 0, 1));
        vecs.push_back(mk(1, 0, 1, 18'h00012, 0,  3'd3, 1, 1, 18'h00010, 0, 1));
        vecs.push_back(mk(1, 0, 1, 18'h00013, 0,  3'd4, 0, 1, 18'h00010, 0, 1));
        vecs.push_back(mk(1, 0, 1, 18'h00014, 1,  3'd3, 1, 1, 18'h00011, 0, 1)); // 16 full + pop
        vecs.push_back(mk(1, 0, 1, 18'h00014, 0,  3'd4, 0, 1, 18'h00011, 0, 1)); // 17 retry
        vecs.push_back(mk(1, 0, 0, 18'h00000, 1,  3'd3, 1, 1, 18'h00012, 0, 1)); // 18 last=0x11
        vecs.push_back(mk(1, 1, 1, 18'h00020, 1,  3'd0, 1, 0, 18'h00011, 1, 0)); // 19 flush
        vecs.push_back(mk(1, 0, 0, 18'h00000, 0,  3'd0, 1, 0, 18'h00011, 1, 0));
        vecs.push_back(mk(1, 0, 1, 18'h00021, 1,  3'd1, 1, 1, 18'h00021, 1, 1)); // 21 no bypass
        vecs.push_back(mk(1, 1, 0, 18'h00000, 0,  3'd0, 1, 0, 18'h00011, 1, 0)); // 22 flush
        vecs.push_back(mk(1, 0, 1, 18'h00030, 0,  3'd1, 1, 1, 18'h00030, 1, 0));
        vecs.push_back(mk(1, 0, 1, 18'h00031, 0,  3'd2, 1, 1, 18'h00030, 0, 0));
        vecs.push_back(mk(1, 0, 0, 18'h00000, 1,  3'd1, 1, 1, 18'h00031, 1, 0));
        vecs.push_back(mk(0, 0, 1, 18'h00032, 1,  3'd0, 1, 0, 18'h00000, 1, 0)); // 26 mid reset

        rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        rst8_n = 1'b0; flush8 = 1'b0; wr_valid8 = 1'b0; wr_data8 = '0; rd_ready8 = 1'b0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n    = vecs[i].rst_n;
            flush    = vecs[i].flush;
            wr_valid = vecs[i].wr_valid;
            wr_data  = vecs[i].wr_data;
            rd_ready = vecs[i].rd_ready;
            @(posedge clk);
            #1;
            check("level",     i, 32'(level),     32'(vecs[i].lvl));
            check("wr_ready",  i, 32'(wr_ready),  32'(vecs[i].wrdy));
            check("rd_valid",  i, 32'(rd_valid),  32'(vecs[i].rv));
            check("rd_data",   i, 32'(rd_data),   32'(vecs[i].rd));
            check("fetch_req", i, 32'(fetch_req), 32'(vecs[i].fr));
            check("underrun",  i, 32'(underrun),  32'(vecs[i].ur));
        end

        // Steady stream from empty: after the first push, level stays at 1 and words emerge in order.
        @(negedge clk);
        rst_n = 1'b1; flush = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wr_valid = 1'b1;
            rd_ready = 1'b1;
            wr_data  = 18'h00100 + 18'(i);
            @(posedge clk);
            #1;
            check("stream_level", 100 + i, 32'(level),    32'd1);
            check("stream_valid", 100 + i, 32'(rd_valid), 32'd1);
            check("stream_data",  100 + i, 32'(rd_data),  32'h100 + 32'(i));
            @(negedge clk);
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;

        // 8-deep, 12-bit, no-hold build: fill to full, reject one, then drain past empty.
        @(negedge clk);
        rst8_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wr_valid8 = 1'b1;
            wr_data8  = 12'hA00 + 12'(i);
            @(posedge clk);
            #1;
            check("d8_fill_level", 200 + i, 32'(level8),     (i < 8) ? 32'(i + 1) : 32'd8);
            check("d8_fill_fetch", 200 + i, 32'(fetch_req8), (i + 1 <= 3) ? 32'd1 : 32'd0);
            check("d8_fill_wrdy",  200 + i, 32'(wr_ready8),  (i + 1 < 8) ? 32'd1 : 32'd0);
            check("d8_fill_head",  200 + i, 32'(rd_data8),   32'hA00);
            @(negedge clk);
        end
        wr_valid8 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            rd_ready8 = 1'b1;
            @(posedge clk);
            #1;
            check("d8_drain_level", 300 + i, 32'(level8),     (i < 8) ? 32'(7 - i) : 32'd0);
            check("d8_drain_fetch", 300 + i, 32'(fetch_req8), (i >= 4) ? 32'd1 : 32'd0);
            check("d8_drain_data",  300 + i, 32'(rd_data8),   (i < 7) ? 32'hA01 + 32'(i) : 32'h000);
            check("d8_drain_valid", 300 + i, 32'(rd_valid8),  (i < 7) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        rd_ready8 = 1'b0;
        check("d8_underrun", 400, 32'(underrun8), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
